uart_rx_ext: RTL
================

# uart_rx_ext

Parametrised oversampling UART receiver, the successor to the fixed 8N1 receiver. It adds configurable data width, parity and stop bits, 3-sample majority voting at bit centre, and per-frame parity, framing and break reporting. The block sits between the synchronised pad input and the byte-stream consumer (FIFO or command decoder). It delivers one word per received frame as a single-cycle strobe.

## Interface
- CLOCK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- OVERSAMPLE, 16: sample ticks per bit; legal values are 8 and 16.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal values 1 or 2.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_uart_rx  input  1  raw serial line; idles high.
- o_uart_data  output  DATA_BITS  received word, LSB first on the line; held until the next valid strobe.
- o_data_valid  output  1  one-cycle strobe for a completed, non-break frame.
- o_parity_err  output  1  qualifies o_data_valid; high when the parity check failed. Always 0 when PARITY=0.
- o_frame_err  output  1  qualifies o_data_valid; high when any stop bit sampled 0.
- o_break  output  1  one-cycle strobe when a break condition is detected.

## Operation
- Input path: 2-FF synchroniser, then a registered copy for falling-edge detection.
- Tick generator:
  - DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division. DIV < 2 is an elaboration error.
  - Counter width is $clog2(DIV).
  - The counter is held at 0 in IDLE and restarts on start-edge detection.
  - One tick per DIV clocks.
- Bit timing:
  - A tick counter counts 0..OVERSAMPLE-1 within each bit.
  - Samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the majority of these 3 samples, evaluated at tick OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE: on a synchronised falling edge, go to START.
  - START: at the vote, a voted 0 goes to DATA with bit index 0. A voted 1 is a glitch: return to IDLE with no output.
  - DATA: shift in one bit per bit period, LSB first. After bit DATA_BITS-1, go to PARITY if PARITY≠0, else to STOP.
  - PARITY: vote the parity bit. Expected parity is XOR(data) ^ (PARITY==1); this makes the total count of 1s odd for odd parity and even for even parity.
  - STOP: vote STOP_BITS stop bits; any 0 sets the frame-error flag.
    - After the final stop vote: if the data is all zero, the parity bit (when present) is 0 and every stop bit is 0, pulse o_break and go to BRK_WAIT.
    - Otherwise load o_uart_data and the flags, pulse o_data_valid, and go to IDLE.
  - BRK_WAIT: stay until the synchronised line is high, then go to IDLE. No edge detection occurs while here.
- Framing errors are reported, not suppressed: data is delivered with o_frame_err=1.
- An unreachable state encoding returns to IDLE on the next clock.
- Reset values:
  - State IDLE, all counters 0.
  - o_uart_data = 0.
  - o_data_valid, o_parity_err, o_frame_err and o_break all 0.
  - Synchroniser flops reset to 1 (line idle), so release of reset never produces a false edge.

## Timing
- Edge-to-detection latency: 3 clocks (2 sync stages plus the edge register).
- o_data_valid and the flags are registered. They rise 1 clock after the clock on which the final stop-bit vote is evaluated, and stay high exactly 1 clock.
- o_parity_err and o_frame_err are meaningful only while o_data_valid=1, and are driven 0 otherwise.
- o_uart_data changes only in the same cycle that o_data_valid rises.
- The receiver is back in IDLE in the same cycle the strobe is issued. A start edge arriving during that cycle is detected, so back-to-back frames with the minimum stop length are accepted.
- No backpressure: the consumer must accept the strobe. An unread word is overwritten by the next frame.
- Reset asserted mid-frame:
  - All outputs clear asynchronously and the partial frame is discarded.
  - After release, the next falling edge starts a fresh frame.

## Test plan
- Set CLOCK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16 (DIV=10) for the directed tests.
- 8N1, send 0x55 then 0xA3 back-to-back with 1 stop bit -> two strobes: 0x55 then 0xA3, all flags 0, strobes exactly 10 bit times apart.
- 7E2, send 0x41 with a correct parity bit, then 0x41 with the parity bit inverted -> first strobe flags 0; second strobe 0x41 with o_parity_err=1 and o_frame_err=0.
- 8N1, send 0x3C with the stop bit driven 0, then the line high -> strobe 0x3C, o_frame_err=1, o_break=0.
- Line low for 20 bit times, then high -> exactly one o_break pulse, no o_data_valid; a following 0x5A frame is received correctly.
- Low glitch lasting 4 sample ticks, and a single-tick dropout at the bit centre of a data bit -> the glitch produces no strobe; the dropout is rejected by the majority vote and the data is correct.
- Assert rst during bit 4 of a frame -> all outputs are 0 immediately, no strobe for that frame; a frame sent after release is received intact.

Source files
------------

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampling UART receiver with configurable data width,
// parity and stop bits, 3-sample majority voting at bit centre, and
// per-frame parity / framing / break reporting.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   i_uart_rx     raw serial line (idles high)
//   o_uart_data   received word, held until the next valid strobe
//   o_data_valid  one-cycle strobe per completed non-break frame
//   o_parity_err  parity check failed (qualifies o_data_valid)
//   o_frame_err   a stop bit sampled 0 (qualifies o_data_valid)
//   o_break       one-cycle strobe on break detection
module uart_rx_ext #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_uart_rx,
  output logic [DATA_BITS-1:0] o_uart_data,
  output logic                 o_data_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break
);

  localparam int unsigned DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW    = $clog2(OVERSAMPLE);
  localparam int unsigned BW    = $clog2(DATA_BITS + 1);
  localparam int unsigned S_LO  = OVERSAMPLE / 2 - 1;
  localparam int unsigned S_MID = OVERSAMPLE / 2;
  localparam int unsigned S_HI  = OVERSAMPLE / 2 + 1;
  localparam logic        HAS_PAR = 1'(PARITY != 0);
  localparam logic        ODD_PAR = 1'(PARITY == 1);

  // Reject illegal parameterisations at elaboration
  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_ext: CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 2");
  end
  if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_os
    $error("uart_rx_ext: OVERSAMPLE must be 8 or 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_rx_ext: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_par
    $error("uart_rx_ext: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_ext: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, rx_d_q;
  logic [DW-1:0]        div_q, div_d;
  logic [SW-1:0]        sidx_q, sidx_d;
  logic [1:0]           smp_q, smp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 stop1_q, stop1_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 dv_d, pe_d, fe_d, brk_d;

  logic fall_c, tick_c, vote_en_c, vote_c, in_frame_c;

  assign fall_c     = rx_d_q & ~sync2_q;
  assign tick_c     = (div_q == DW'(DIV - 1));
  assign in_frame_c = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);
  assign vote_en_c  = in_frame_c && tick_c && (sidx_q == SW'(S_HI));
  // Third sample is the live synchronised line at the vote tick
  assign vote_c     = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) |
                      (smp_q[1] & sync2_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sidx_d  = sidx_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    stop1_d = stop1_q;
    data_d  = o_uart_data;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    brk_d   = 1'b0;

    // Baud tick and per-bit sample position while inside a frame
    if (in_frame_c) begin
      div_d = tick_c ? '0 : div_q + DW'(1);
      if (tick_c) begin
        sidx_d = sidx_q + SW'(1);
        if (sidx_q == SW'(S_LO))  smp_d[0] = sync2_q;
        if (sidx_q == SW'(S_MID)) smp_d[1] = sync2_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        div_d  = '0;
        sidx_d = '0;
        if (fall_c) begin
          state_d = S_START;
          bit_d   = '0;
          ferr_d  = 1'b0;
          stop1_d = 1'b0;
        end
      end
      S_START: begin
        if (vote_en_c) begin
          // A voted 1 means the edge was a glitch
          state_d = vote_c ? S_IDLE : S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (vote_en_c) begin
          shift_d = {vote_c, shift_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (vote_en_c) begin
          par_d   = vote_c;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (vote_en_c) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            // All-zero frame including parity and stop bits is a break
            if ((shift_q == '0) && !(HAS_PAR && par_q) && !stop1_q && !vote_c) begin
              brk_d   = 1'b1;
              state_d = S_BRK_WAIT;
            end else begin
              data_d  = shift_q;
              dv_d    = 1'b1;
              pe_d    = HAS_PAR & (par_q ^ (^shift_q) ^ ODD_PAR);
              fe_d    = ferr_q | ~vote_c;
              state_d = S_IDLE;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            ferr_d  = ferr_q | ~vote_c;
            stop1_d = stop1_q | vote_c;
          end
        end
      end
      S_BRK_WAIT: begin
        div_d  = '0;
        sidx_d = '0;
        if (sync2_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        sidx_d  = '0;
      end
    endcase
  end

  // Synchroniser, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_d_q       <= 1'b1;
      div_q        <= '0;
      sidx_q       <= '0;
      smp_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      ferr_q       <= 1'b0;
      stop1_q      <= 1'b0;
      o_uart_data  <= '0;
      o_data_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      sync1_q      <= i_uart_rx;
      sync2_q      <= sync1_q;
      rx_d_q       <= sync2_q;
      div_q        <= div_d;
      sidx_q       <= sidx_d;
      smp_q        <= smp_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      ferr_q       <= ferr_d;
      stop1_q      <= stop1_d;
      o_uart_data  <= data_d;
      o_data_valid <= dv_d;
      o_parity_err <= pe_d;
      o_frame_err  <= fe_d;
      o_break      <= brk_d;
    end
  end

endmodule
